// File: rtl/strum_judge_ctrl.sv
// strum_judge_ctrl
//   Sequencing controller for the note-hit scoring datapath. Conditions the
//   raw strum bar input, judges each strum against the fret buttons and the
//   lane intersections, keeps score / streak / multiplier and hands every new
//   score to the processor (written into r28) over a req/ack handshake.
//
//   Build option: define STRUM_DEBOUNCE_EN to add the strum debouncer
//   (DEBOUNCE_CYCLES of stable level before a change is accepted). Without
//   it the synchronized level is used directly.
//
// Ports
//   clock, reset_n       system clock, synchronous active-low reset
//   strum_raw            asynchronous strum bar level
//   buttons[3:0]         fret button levels, lanes 0..3
//   intersections[3:0]   lane has a note inside the hit window
//   note_expired         1-cycle pulse, a note left the window unjudged
//   score_wr_ack         processor accepted score_wr_data
//   score_wr_req         score update pending
//   score_wr_data[31:0]  score value for r28
//   streak               consecutive-hit count
//   multiplier[2:0]      current multiplier, 1..MAX_MULT
//   hit_pulse            1-cycle pulse on a judged hit
//   miss_pulse           1-cycle pulse on a judged miss or expiry
module strum_judge_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int POINTS_PER_NOTE = 10,
    parameter int STREAK_PER_MULT = 10,
    parameter int MAX_MULT        = 4,
    parameter int STREAK_W        = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                strum_raw,
    input  logic [3:0]          buttons,
    input  logic [3:0]          intersections,
    input  logic                note_expired,
    input  logic                score_wr_ack,
    output logic                score_wr_req,
    output logic [31:0]         score_wr_data,
    output logic [STREAK_W-1:0] streak,
    output logic [2:0]          multiplier,
    output logic                hit_pulse,
    output logic                miss_pulse
);
    typedef enum logic [1:0] {IDLE, JUDGE, WAIT_ACK} state_t;

    state_t              state, state_nxt;
    logic                sync1, sync2, deb, deb_q, strum_evt;
    logic                pending, pending_nxt;
    logic [3:0]          cap_btn, cap_btn_nxt, cap_int, cap_int_nxt;
    logic [STREAK_W-1:0] streak_nxt;
    logic [2:0]          mult_nxt;
    logic [31:0]         data_nxt;
    logic                req_nxt, hit_nxt, miss_nxt, hit;
    logic [32:0]         sum;

    // ---------------- strum conditioning ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb_q <= 1'b0;
        end else begin
            sync1 <= strum_raw;
            sync2 <= sync1;
            deb_q <= deb;
        end
    end

`ifdef STRUM_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] deb_cnt;

    // Counter only runs while the synchronized level disagrees with the
    // accepted level; any return to agreement restarts the qualification.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (sync2 == deb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb     <= sync2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end
`else
    assign deb = sync2;
`endif

    assign strum_evt = deb & ~deb_q;

    // ---------------- judge datapath ----------------
    function automatic logic [2:0] mult_of(input logic [STREAK_W-1:0] s);
        logic [STREAK_W-1:0] steps;
        steps = s / STREAK_W'(STREAK_PER_MULT);
        if (steps >= STREAK_W'(MAX_MULT - 1)) return 3'(MAX_MULT);
        return 3'(steps + 1'b1);
    endfunction

    assign hit = (cap_int != 4'd0) && (cap_btn == cap_int);
    // Uses the multiplier in force before this hit is counted.
    assign sum = {1'b0, score_wr_data} + 33'(POINTS_PER_NOTE) * {30'd0, multiplier};

    // ---------------- FSM: next state / outputs ----------------
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        cap_btn_nxt = cap_btn;
        cap_int_nxt = cap_int;
        streak_nxt  = streak;
        mult_nxt    = multiplier;
        data_nxt    = score_wr_data;
        req_nxt     = score_wr_req;
        hit_nxt     = 1'b0;
        miss_nxt    = 1'b0;

        // One strum can be parked; anything arriving on top of it is lost.
        if (strum_evt && !pending) begin
            cap_btn_nxt = buttons;
            cap_int_nxt = intersections;
        end

        case (state)
            IDLE: begin
                if (strum_evt || pending) begin
                    state_nxt   = JUDGE;
                    pending_nxt = 1'b0;
                end
                // A strum in the same cycle takes priority over the expiry.
                if (note_expired && !strum_evt) begin
                    streak_nxt = '0;
                    mult_nxt   = 3'd1;
                    miss_nxt   = 1'b1;
                end
            end
            JUDGE: begin
                if (hit) begin
                    if (streak != '1) streak_nxt = streak + 1'b1;
                    data_nxt = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
                    hit_nxt  = 1'b1;
                end else begin
                    streak_nxt = '0;
                    miss_nxt   = 1'b1;
                end
                mult_nxt  = mult_of(streak_nxt);
                req_nxt   = 1'b1;
                state_nxt = WAIT_ACK;
                if (strum_evt && !pending) pending_nxt = 1'b1;
            end
            WAIT_ACK: begin
                if (score_wr_ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
                // Expiry resets the streak but the in-flight score stays put.
                if (note_expired) begin
                    streak_nxt = '0;
                    mult_nxt   = 3'd1;
                    miss_nxt   = 1'b1;
                end
                if (strum_evt && !pending) pending_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            pending       <= 1'b0;
            cap_btn       <= 4'd0;
            cap_int       <= 4'd0;
            streak        <= '0;
            multiplier    <= 3'd1;
            score_wr_data <= 32'd0;
            score_wr_req  <= 1'b0;
            hit_pulse     <= 1'b0;
            miss_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            pending       <= pending_nxt;
            cap_btn       <= cap_btn_nxt;
            cap_int       <= cap_int_nxt;
            streak        <= streak_nxt;
            multiplier    <= mult_nxt;
            score_wr_data <= data_nxt;
            score_wr_req  <= req_nxt;
            hit_pulse     <= hit_nxt;
            miss_pulse    <= miss_nxt;
        end
    end
endmodule

// File: tb/tb_strum_judge_ctrl.sv
// Self-checking bench for strum_judge_ctrl: stimulus pushes expected judge
// outcomes and score writes into queues, a monitor pops them whenever the
// DUT pulses hit/miss or raises score_wr_req.
module tb_strum_judge_ctrl;
    localparam int DEB  = 4;
    localparam int PPN  = 10;
    localparam int SPM  = 10;
    localparam int MAXM = 4;
    localparam int SW   = 6;
    localparam int SMAX = (1 << SW) - 1;

    logic          clock = 1'b0;
    logic          reset_n, strum_raw, note_expired;
    logic [3:0]    buttons, intersections;
    logic          ack_drv = 1'b0, ack_spur = 1'b0;
    logic          score_wr_req, hit_pulse, miss_pulse;
    logic [31:0]   score_wr_data;
    logic [SW-1:0] streak;
    logic [2:0]    multiplier;

    strum_judge_ctrl #(.DEBOUNCE_CYCLES(DEB), .POINTS_PER_NOTE(PPN),
                       .STREAK_PER_MULT(SPM), .MAX_MULT(MAXM), .STREAK_W(SW)) dut (
        .clock(clock), .reset_n(reset_n), .strum_raw(strum_raw), .buttons(buttons),
        .intersections(intersections), .note_expired(note_expired),
        .score_wr_ack(ack_drv | ack_spur), .score_wr_req(score_wr_req),
        .score_wr_data(score_wr_data), .streak(streak), .multiplier(multiplier),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse));

    always #5 clock = ~clock;

    typedef struct { bit hit; int streak; int mult; } ev_t;
    ev_t    exp_ev[$];
    longint exp_data[$];
    int     errors = 0, checks = 0;
    longint m_score = 0;
    int     m_streak = 0;
    int     ack_dly = 1;
    bit     ack_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int mult_of(input int s);
        int m = 1 + s / SPM;
        return (m > MAXM) ? MAXM : m;
    endfunction

    task automatic push_ev(input bit h);
        ev_t ev;
        ev.hit = h; ev.streak = m_streak; ev.mult = mult_of(m_streak);
        exp_ev.push_back(ev);
    endtask

    task automatic model_judge(input logic [3:0] b, input logic [3:0] i);
        bit h = (i != 4'd0) && (b == i);
        if (h) begin
            m_score = m_score + PPN * mult_of(m_streak);
            if (m_score > 64'hFFFF_FFFF) m_score = 64'hFFFF_FFFF;
            if (m_streak < SMAX) m_streak++;
        end else begin
            m_streak = 0;
        end
        push_ev(h);
        exp_data.push_back(m_score);
    endtask

    task automatic model_expire();
        m_streak = 0;
        push_ev(1'b0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic strum(input logic [3:0] b, input logic [3:0] i, input bit judged);
        buttons = b; intersections = i;
        if (judged) model_judge(b, i);
        strum_raw = 1'b1; repeat (10) @(negedge clock);
        strum_raw = 1'b0; repeat (10) @(negedge clock);
    endtask

    task automatic pulse_expire();
        note_expired = 1'b1; @(negedge clock);
        note_expired = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0, n = 0;
        while (quiet < 6 && n < 400) begin
            @(negedge clock); n++;
            if (exp_ev.size() == 0 && exp_data.size() == 0 && !score_wr_req) quiet++;
            else quiet = 0;
        end
        if (quiet < 6) begin
            checks++; errors++;
            $display("FAIL wait_idle: timeout, %0d events %0d writes outstanding",
                     exp_ev.size(), exp_data.size());
        end
    endtask

    task automatic chk_state(input string name);
        chk({name, "_streak"}, 64'(streak), 64'(m_streak));
        chk({name, "_mult"}, 64'(multiplier), 64'(mult_of(m_streak)));
    endtask

    // ---------------- processor ack model ----------------
    initial forever begin
        @(negedge clock);
        if (score_wr_req === 1'b1 && ack_en) begin
            repeat (ack_dly) @(negedge clock);
            ack_drv = 1'b1; @(negedge clock);
            ack_drv = 1'b0;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic   req_q = 1'b0;
        longint cur = 0;
        ev_t    ev;
        forever begin
            @(negedge clock);
            if (hit_pulse === 1'b1 || miss_pulse === 1'b1) begin
                if (exp_ev.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pulse: hit=%b miss=%b at %0t", hit_pulse, miss_pulse, $time);
                end else begin
                    ev = exp_ev.pop_front();
                    chk("pulse_hit", 64'(hit_pulse), 64'(ev.hit));
                    chk("pulse_miss", 64'(miss_pulse), 64'(!ev.hit));
                    chk("pulse_streak", 64'(streak), 64'(ev.streak));
                    chk("pulse_mult", 64'(multiplier), 64'(ev.mult));
                end
            end
            if (score_wr_req === 1'b1 && !req_q) begin
                if (exp_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: data=%0h at %0t", score_wr_data, $time);
                end else begin
                    cur = exp_data.pop_front();
                    chk("wr_data", 64'(score_wr_data), 64'(cur));
                end
            end else if (score_wr_req === 1'b1) begin
                chk("wr_data_stable", 64'(score_wr_data), 64'(cur));
            end
            req_q = score_wr_req;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] b, i;
        int kind;
        reset_n = 1'b0; strum_raw = 1'b0; note_expired = 1'b0;
        buttons = 4'd0; intersections = 4'd0;
        repeat (3) @(negedge clock);
        chk("rst_req", 64'(score_wr_req), 64'd0);
        chk("rst_data", 64'(score_wr_data), 64'd0);
        chk("rst_streak", 64'(streak), 64'd0);
        chk("rst_mult", 64'(multiplier), 64'd1);
        chk("rst_hit", 64'(hit_pulse), 64'd0);
        chk("rst_miss", 64'(miss_pulse), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Single hit worth 10 points.
        strum(4'b0101, 4'b0101, 1'b1);
        wait_idle();
        chk("hit1_streak", 64'(streak), 64'd1);
        chk("hit1_score", 64'(score_wr_data), 64'd10);

        // Ten more hits: the 11th hit scores at x2.
        repeat (10) begin strum(4'b0011, 4'b0011, 1'b1); wait_idle(); end
        chk("streak11", 64'(streak), 64'd11);
        chk("mult11", 64'(multiplier), 64'd2);
        chk("score120", 64'(score_wr_data), 64'd120);

        // Wrong fret: miss, score unchanged but still written.
        strum(4'b0011, 4'b0010, 1'b1);
        wait_idle();
        chk_state("wrongfret");

        // Expiry in IDLE after a 5-hit streak.
        repeat (5) begin strum(4'b1000, 4'b1000, 1'b1); wait_idle(); end
        model_expire(); pulse_expire();
        wait_idle();
        chk_state("expire_idle");

        // Busy strums: ack withheld long enough that both follow-ups land in
        // WAIT_ACK; the second is parked and judged later, the third is lost.
        ack_dly = 50;
        strum(4'b0001, 4'b0001, 1'b1);
        strum(4'b0110, 4'b0110, 1'b1);
        strum(4'b1111, 4'b1111, 1'b0);
        ack_dly = 2;
        wait_idle();
        chk_state("busy");

`ifdef STRUM_DEBOUNCE_EN
        // Bouncing strum bar: only the final steady level counts.
        buttons = 4'b0100; intersections = 4'b0100;
        model_judge(4'b0100, 4'b0100);
        for (int k = 0; k < 10; k++) begin strum_raw = ~strum_raw; repeat (2) @(negedge clock); end
        strum_raw = 1'b1; repeat (10) @(negedge clock);
        strum_raw = 1'b0; repeat (10) @(negedge clock);
        wait_idle();
        chk_state("bounce");
`endif

        // Ack while nothing is pending must be ignored.
        ack_spur = 1'b1; repeat (3) @(negedge clock); ack_spur = 1'b0;
        @(negedge clock);
        chk("spur_ack_req", 64'(score_wr_req), 64'd0);

        // Long hit run: multiplier ceiling and streak saturation.
        ack_dly = 0;
        repeat (SMAX + 3) begin strum(4'b0010, 4'b0010, 1'b1); wait_idle(); end
        chk("sat_streak", 64'(streak), 64'(SMAX));
        chk("sat_mult", 64'(multiplier), 64'(MAXM));

        // Randomized mix.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            i = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 3) != 0) ? i : 4'($urandom_range(0, 15));
            ack_dly = $urandom_range(0, 4);
            case (kind)
                0: strum(b, i, 1'b1);
                1: begin
                    ack_dly = 30;
                    strum(b, i, 1'b1);
                    if (score_wr_req) begin model_expire(); pulse_expire(); end
                end
                2: begin
                    ack_dly = 50;
                    strum(b, i, 1'b1);
                    strum(i, b, 1'b1);
                    strum(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
                    ack_dly = 1;
                end
                default: begin model_expire(); pulse_expire(); end
            endcase
            wait_idle();
            chk_state("rand");
        end

        // Reset in the middle of a handshake.
        ack_en = 1'b0;
        strum(4'b1001, 4'b1001, 1'b1);
        @(negedge clock);
        chk("pre_rst_req", 64'(score_wr_req), 64'd1);
        reset_n = 1'b0; @(negedge clock);
        chk("midrst_req", 64'(score_wr_req), 64'd0);
        chk("midrst_data", 64'(score_wr_data), 64'd0);
        chk("midrst_streak", 64'(streak), 64'd0);
        chk("midrst_mult", 64'(multiplier), 64'd1);
        reset_n = 1'b1; m_score = 0; m_streak = 0; ack_en = 1'b1;
        wait_idle();

        chk("left_events", 64'(exp_ev.size()), 64'd0);
        chk("left_writes", 64'(exp_data.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
